// File: rtl/module_sumador_segmentado.sv
// module_sumador_segmentado: pipelined adder/subtractor with one carry segment per stage
// and valid/ready flow control; the whole pipeline stalls while the output is held.
module module_sumador_segmentado #(
  parameter int ANCHO  = 8,
  parameter int ETAPAS = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             listo_o,
  input  logic [ANCHO-1:0] A,
  input  logic [ANCHO-1:0] B,
  input  logic             resta_i,
  output logic [ANCHO-1:0] S,
  output logic             cout_o,
  output logic             desborde_o,
  output logic             valid_o,
  input  logic             listo_i
);
  localparam int E = (ETAPAS < 1) ? 1 : ETAPAS;
  localparam int W = ANCHO / E;
  if (ETAPAS < 1 || ANCHO % E != 0) begin : g_chk
    $error("ANCHO must be a multiple of ETAPAS and ETAPAS >= 1");
  end
  logic [ANCHO-1:0] a_q [E], b_q [E], s_q [E], a_d [E], b_d [E], s_d [E], s_e [E];
  logic             v_q [E], c_q [E], r_q [E], v_d [E], c_d [E], r_d [E], c_e [E];
  logic [W:0]       t [E];
  logic             o_q, o_d, avance;
  assign avance  = !valid_o || listo_i;
  assign listo_o = avance;
  // a/b travel whole; stage k consumes slice k and merges its result into the partial sum
  always_comb begin
    a_d[0] = A;
    b_d[0] = resta_i ? ~B : B;
    s_e[0] = '0;
    c_e[0] = resta_i;
    r_d[0] = resta_i;
    v_d[0] = valid_i;
    for (int k = 1; k < E; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      s_e[k] = s_q[k-1];
      c_e[k] = c_q[k-1];
      r_d[k] = r_q[k-1];
      v_d[k] = v_q[k-1];
    end
    for (int k = 0; k < E; k++) begin
      t[k] = {1'b0, a_d[k][k*W +: W]} + {1'b0, b_d[k][k*W +: W]} + {{W{1'b0}}, c_e[k]};
      s_d[k] = s_e[k];
      s_d[k][k*W +: W] = t[k][W-1:0];
      c_d[k] = t[k][W];
    end
    o_d = (a_d[E-1][ANCHO-1] == b_d[E-1][ANCHO-1]) && (s_d[E-1][ANCHO-1] != a_d[E-1][ANCHO-1]);
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < E; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        r_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      o_q <= 1'b0;
    end else if (avance) begin
      for (int k = 0; k < E; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        r_q[k] <= r_d[k];
        v_q[k] <= v_d[k];
      end
      o_q <= o_d;
    end
  end
  assign S          = s_q[E-1];
  assign cout_o     = c_q[E-1];
  assign valid_o    = v_q[E-1];
  assign desborde_o = o_q;
endmodule

// File: tb/tb_module_sumador_segmentado.sv
// tb_module_sumador_segmentado: directed vectors and stall/reset sequences on an 8/2 instance,
// plus random traffic on four configurations against an arithmetic reference model.
module tb_module_sumador_segmentado;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int pas = 0, tot = 0, n_done = 0;
  logic rst_n, rst_r_n;
  task automatic chk(input string nm, input longint act, input longint exp);
    tot++;
    if (act == exp) pas++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  typedef struct {
    logic [7:0] a, b;
    logic       r;
    logic [7:0] s;
    logic       c, o;
  } vec_t;
  logic [7:0] a, b, s;
  logic r, vi, li, lo, vo, co, ov;
  module_sumador_segmentado #(.ANCHO(8), .ETAPAS(2)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(vi), .listo_o(lo), .A(a), .B(b), .resta_i(r),
    .S(s), .cout_o(co), .desborde_o(ov), .valid_o(vo), .listo_i(li)
  );
  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int N = (g == 1) ? 16 : 8;
    localparam int E = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 8;
    localparam longint M = longint'(1) << N;
    logic [N-1:0] ra, rb, rs;
    logic rr, rvi, rli, rlo, rvo, rco, rov;
    longint q[$];
    module_sumador_segmentado #(.ANCHO(N), .ETAPAS(E)) u (
      .clk_i(clk), .rst_n_i(rst_r_n), .valid_i(rvi), .listo_o(rlo), .A(ra), .B(rb), .resta_i(rr),
      .S(rs), .cout_o(rco), .desborde_o(rov), .valid_o(rvo), .listo_i(rli)
    );
    initial begin
      int sent, cyc;
      logic acc;
      longint ua, ub, sa, sb, sr, ex;
      sent = 0;
      cyc = 0;
      acc = 1'b0;
      {ra, rb, rr, rvi, rli} = '0;
      wait (rst_r_n === 1'b1);
      while ((sent < 1000 || q.size() != 0) && cyc < 10000) begin
        @(negedge clk);
        cyc++;
        if (!(rvi && !acc)) begin
          rvi = sent < 1000 && $urandom_range(0, 3) != 0;
          ra = N'($urandom);
          rb = N'($urandom);
          rr = 1'($urandom);
        end
        rli = $urandom_range(0, 3) != 0;
        #1;
        acc = rvi && rlo;
        if (rvo && rli) begin
          ex = (q.size() != 0) ? q.pop_front() : -1;
          chk($sformatf("rnd%0d_out", g), longint'({rov, rco, rs}), ex);
        end
        if (acc) begin
          ua = longint'(ra);
          ub = longint'(rb);
          sa = (ua >= M / 2) ? ua - M : ua;
          sb = (ub >= M / 2) ? ub - M : ub;
          sr = rr ? sa - sb : sa + sb;
          ex = ((rr ? ua - ub : ua + ub) % M + M) % M;
          ex |= longint'(rr ? ua >= ub : ua + ub >= M) << N;
          ex |= longint'(sr < -M / 2 || sr >= M / 2) << (N + 1);
          q.push_back(ex);
          sent++;
        end
      end
      chk($sformatf("rnd%0d_complete", g), longint'(cyc < 10000), 1);
      rvi = 1'b0;
      rli = 1'b1;
      repeat (E + 2) @(negedge clk);
      #1;
      chk($sformatf("rnd%0d_drain", g), longint'(rvo), 0);
      n_done++;
    end
  end
  initial begin
    vec_t tv [8];
    logic [7:0] want [4];
    int idx, outn;
    tv[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tv[2] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tv[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    tv[4] = '{8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0};
    tv[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tv[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tv[7] = '{8'h00, 8'h80, 1'b1, 8'h80, 1'b0, 1'b1};
    want = '{8'h02, 8'h04, 8'h06, 8'h08};
    rst_n = 1'b0;
    rst_r_n = 1'b0;
    {a, b, r, vi} = '0;
    li = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", longint'(vo), 0);
    chk("rst_s", longint'(s), 0);
    chk("rst_cout", longint'(co), 0);
    chk("rst_ovf", longint'(ov), 0);
    chk("rst_listo", longint'(lo), 1);
    rst_n = 1'b1;
    rst_r_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {a, b, r, vi} = {tv[i].a, tv[i].b, tv[i].r, 1'b1};
      @(negedge clk);
      vi = 1'b0;
      #1;
      chk($sformatf("vec%0d_early", i), longint'(vo), 0);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), longint'(vo), 1);
      chk($sformatf("vec%0d_s", i), longint'(s), longint'(tv[i].s));
      chk($sformatf("vec%0d_cout", i), longint'(co), longint'(tv[i].c));
      chk($sformatf("vec%0d_ovf", i), longint'(ov), longint'(tv[i].o));
    end
    idx = 0;
    outn = 0;
    for (int c = 0; c < 30 && outn < 4; c++) begin
      @(negedge clk);
      li = !(c >= 2 && c <= 4);
      vi = idx < 4;
      a = 8'(idx + 1);
      b = 8'(idx + 1);
      r = 1'b0;
      #1;
      if (!li) begin
        chk("stall_listo", longint'(lo), 0);
        chk("stall_valid", longint'(vo), 1);
        chk("stall_s", longint'(s), 8'h02);
      end
      if (vo && li) begin
        chk($sformatf("seq_out%0d", outn), longint'(s), longint'(want[outn]));
        outn++;
      end
      if (vi && lo) idx++;
    end
    chk("seq_count", outn, 4);
    vi = 1'b0;
    li = 1'b1;
    @(negedge clk);
    #1;
    chk("seq_no_dup", longint'(vo), 0);
    li = 1'b0;
    {vi, a, b, r} = {1'b1, 8'h11, 8'h22, 1'b0};
    @(negedge clk);
    {a, b} = {8'h33, 8'h44};
    @(negedge clk);
    vi = 1'b0;
    #1;
    chk("mid_valid_pre", longint'(vo), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid_async", longint'(vo), 0);
    chk("mid_s_async", longint'(s), 0);
    chk("mid_listo_async", longint'(lo), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    li = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mid_no_stale%0d", i), longint'(vo), 0);
    end
    {vi, a, b, r} = {1'b1, 8'h01, 8'h02, 1'b0};
    @(negedge clk);
    vi = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_valid", longint'(vo), 1);
    chk("post_rst_s", longint'(s), 8'h03);
    for (int i = 0; i < 20000 && n_done < 4; i++) @(negedge clk);
    chk("rnd_all_done", n_done, 4);
    $display("%0d/%0d checks passed", pas, tot);
    $finish;
  end
endmodule

// File: doc/module_sumador_segmentado.md
MODULE_SUMADOR_SEGMENTADO -- requirements
Module: module_sumador_segmentado

Interface
REQ-001 The block SHALL have parameter ANCHO, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter ETAPAS, default 2, giving the number of pipeline stages and carry segments.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit, the reset, asynchronous and active-low.
REQ-005 The block SHALL have port valid_i, input, 1 bit, signalling that the input operands are valid.
REQ-006 The block SHALL have port listo_o, output, 1 bit, signalling that the block accepts an input this cycle.
REQ-007 The block SHALL have port A, input, ANCHO bits, the first operand.
REQ-008 The block SHALL have port B, input, ANCHO bits, the second operand.
REQ-009 The block SHALL have port resta_i, input, 1 bit, selecting the operation: 0 = A+B, 1 = A-B.
REQ-010 The block SHALL have port S, output, ANCHO bits, the result.
REQ-011 The block SHALL have port cout_o, output, 1 bit, the carry out of the MSB.
REQ-012 The block SHALL have port desborde_o, output, 1 bit, the two's-complement signed overflow flag.
REQ-013 The block SHALL have port valid_o, output, 1 bit, signalling that S, cout_o and desborde_o are valid.
REQ-014 The block SHALL have port listo_i, input, 1 bit, signalling that the downstream consumer accepts the output.

Function
REQ-015 ANCHO mod ETAPAS != 0 or ETAPAS < 1 SHALL cause an elaboration error; segment width is W = ANCHO/ETAPAS.
REQ-016 Stage k (0..ETAPAS-1) SHALL ripple-add bits [k*W +: W] using the carry registered by stage k-1; stage 0 SHALL use carry-in = resta_i.
REQ-017 In subtract mode, B SHALL be bitwise inverted before stage 0 and resta_i SHALL be carried with the data through the pipeline.
REQ-018 Unprocessed upper operand slices SHALL be delayed, and finished lower sum slices registered forward, so that all W-bit slices of one transaction reach the output together.
REQ-019 A per-stage valid bit SHALL mark occupied stages; empty stages (bubbles) SHALL be allowed.
REQ-020 Advance condition: avance = !valid_o || listo_i; listo_o SHALL equal avance, combinationally.
REQ-021 An input SHALL be accepted when valid_i && listo_o; valid_i while listo_o=0 SHALL be ignored, and the source SHALL hold it.
REQ-022 When avance=0, every stage and all outputs SHALL hold their values unchanged, with no loss or duplication.
REQ-023 Latency SHALL be exactly ETAPAS cycles from acceptance to valid_o=1 with no stall; throughput SHALL be 1 transaction per cycle.
REQ-024 cout_o SHALL be the final-stage carry; in subtract mode, 1 SHALL mean A >= B unsigned (no borrow).
REQ-025 desborde_o SHALL be 1 iff the MSBs of A and of the effective B are equal and differ from the MSB of S.
REQ-026 Results SHALL be modulo 2^ANCHO; S SHALL wrap, with no saturation.
REQ-027 Outputs SHALL come directly from the last-stage registers, with no combinational path from A, B or resta_i.
REQ-028 ETAPAS=1 SHALL yield a single registered full-width adder with latency 1.

Reset
REQ-029 While rst_n_i=0, all stage valid bits, valid_o, S, cout_o, desborde_o and internal carries SHALL be 0, asynchronously.
REQ-030 After reset, listo_o SHALL be 1, since valid_o=0.
REQ-031 Reset mid-operation SHALL discard all in-flight transactions; none SHALL appear after release.
REQ-032 The first input SHALL be accepted on the first rising clock edge after rst_n_i deasserts.

Verification (ANCHO=8, ETAPAS=2 unless stated)
REQ-033 Add A=FF, B=01, listo_i=1 -> exactly 2 cycles later: valid_o=1, S=00, cout_o=1, desborde_o=0.
REQ-034 Add A=7F, B=01 -> S=80, cout_o=0, desborde_o=1; sub A=80, B=01 -> S=7F, cout_o=1, desborde_o=1.
REQ-035 Sub A=05, B=07 -> S=FE, cout_o=0, desborde_o=0; sub A=07, B=05 -> S=02, cout_o=1.
REQ-036 Four back-to-back inputs (01+01, 02+02, 03+03, 04+04), with listo_i=0 for 3 cycles after the first output -> listo_o=0 during the stall, S=02 held stable, then outputs 02, 04, 06, 08 in order, each once.
REQ-037 Two transactions in flight, rst_n_i pulsed low mid-cycle -> valid_o=0 immediately with no clock edge, and no stale output after release.
REQ-038 ANCHO=16, ETAPAS=4, ETAPAS=1 and ETAPAS=8 (ANCHO=8), with 1000 random vectors, random resta_i, and random valid_i/listo_i -> every output matches the reference model (A±B mod 2^ANCHO, carry and overflow), in order.
